// File: rtl/mult_pkg.sv
// Shared types and ALU control encodings for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } mult_state_t;

  localparam logic [3:0] ALU_S_ADD   = 4'b1001;
  localparam logic       ALU_M_ARITH = 1'b0;

endpackage

// File: rtl/ula_74181.sv
// Behavioural 4-bit ALU in the style of the 74181 (active-high data, carry-in adds one).
module ula_74181 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [3:0] s_i,
  input  logic       m_i,
  input  logic       cin_i,
  output logic [3:0] f_o,
  output logic       cout_o
);

  logic [4:0] sum_s;

  // Function decode: logic ops when m_i=1, arithmetic with carry otherwise.
  always_comb begin
    sum_s  = 5'd0;
    f_o    = 4'd0;
    cout_o = 1'b0;
    if (m_i) begin
      case (s_i)
        4'h0:    f_o = ~a_i;
        4'h1:    f_o = ~(a_i | b_i);
        4'h3:    f_o = 4'h0;
        4'h4:    f_o = ~(a_i & b_i);
        4'h5:    f_o = ~b_i;
        4'h6:    f_o = a_i ^ b_i;
        4'h9:    f_o = ~(a_i ^ b_i);
        4'hA:    f_o = b_i;
        4'hB:    f_o = a_i & b_i;
        4'hC:    f_o = 4'hF;
        4'hE:    f_o = a_i | b_i;
        default: f_o = a_i;
      endcase
    end else begin
      case (s_i)
        4'b0110: sum_s = {1'b0, a_i} + {1'b0, ~b_i} + {4'd0, cin_i};
        4'b1001: sum_s = {1'b0, a_i} + {1'b0, b_i} + {4'd0, cin_i};
        4'b1100: sum_s = {1'b0, a_i} + {1'b0, a_i} + {4'd0, cin_i};
        4'b1111: sum_s = {1'b0, a_i} + 5'h0F + {4'd0, cin_i};
        default: sum_s = {1'b0, a_i} + {4'd0, cin_i};
      endcase
      f_o    = sum_s[3:0];
      cout_o = sum_s[4];
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Shift-add multiplier sequencer; partial-product adds go nibble-serially through an external 4-bit ALU.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic [3:0]         alu_s,
  output logic               alu_m,
  output logic               alu_cin,
  input  logic [3:0]         alu_f,
  input  logic               alu_cout
);

  localparam int NIB = WIDTH / 4;
  localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mult_state_t        state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               carry_q, carry_d;
  logic [BW-1:0]      bitcnt_q, bitcnt_d;
  logic [NW-1:0]      nib_q, nib_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [2*WIDTH-1:0] shifted_s;

  // The final shift is also the value captured as the product, so it is built once here.
  assign shifted_s = {carry_q, hi_q, lo_q[WIDTH-1:1]};

  assign ready   = (state_q == IDLE);
  assign done    = done_q;
  assign product = product_q;
  assign alu_m   = ALU_M_ARITH;

  // Next-state, datapath updates and ALU operand steering.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    carry_d   = carry_q;
    bitcnt_d  = bitcnt_q;
    nib_d     = nib_q;
    done_d    = 1'b0;
    product_d = product_q;
    alu_a     = 4'd0;
    alu_b     = 4'd0;
    alu_s     = 4'd0;
    alu_cin   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a_in;
          lo_d     = b_in;
          hi_d     = '0;
          bitcnt_d = '0;
          state_d  = CHECK;
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        carry_d = 1'b0;
        if (lo_q[0]) begin
          nib_d   = '0;
          state_d = ADD;
        end else begin
          state_d = SHIFT;
        end
      end
      ADD: begin
        alu_a   = hi_q[4*nib_q +: 4];
        alu_b   = mcand_q[4*nib_q +: 4];
        alu_s   = ALU_S_ADD;
        alu_cin = (nib_q == '0) ? 1'b0 : carry_q;
        hi_d[4*nib_q +: 4] = alu_f;
        carry_d = alu_cout;
        if (nib_q == NW'(NIB - 1)) begin
          state_d = SHIFT;
        end else begin
          nib_d = nib_q + NW'(1);
        end
      end
      SHIFT: begin
        {hi_d, lo_d} = shifted_s;
        bitcnt_d     = bitcnt_q + BW'(1);
        if (bitcnt_q == BW'(WIDTH - 1)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          product_d = shifted_s;
        end else begin
          state_d = CHECK;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      carry_q   <= 1'b0;
      bitcnt_q  <= '0;
      nib_q     <= '0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      carry_q   <= carry_d;
      bitcnt_q  <= bitcnt_d;
      nib_q     <= nib_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl driving a 74181-style ALU; reference is plain a*b and a cycle formula.
module tb_mult_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int NIB   = WIDTH / 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   a_in, b_in;
  logic               ready, done;
  logic [2*WIDTH-1:0] product;
  logic [3:0]         alu_a, alu_b, alu_s, alu_f;
  logic               alu_m, alu_cin, alu_cout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .ready(ready), .done(done), .product(product),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout)
  );

  ula_74181 alu (
    .a_i(alu_a), .b_i(alu_b), .s_i(alu_s), .m_i(alu_m), .cin_i(alu_cin),
    .f_o(alu_f), .cout_o(alu_cout)
  );

  typedef struct {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] prod;
    int                 cyc;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int ref_cycle(input logic [WIDTH-1:0] b);
    return 2 * WIDTH + NIB * $countones(b) + 1;
  endfunction

  // Wait for done; edges counted from the accept edge, 0 means the budget ran out.
  task automatic wait_done(output int edges, output bit bnz);
    edges = 0;
    bnz   = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (alu_b != 4'd0) bnz = 1'b1;
      if (done) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2*WIDTH-1:0] exp_prod, input int exp_cyc, output bit bnz);
    int edges;
    a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_in  = WIDTH'($urandom);
    b_in  = WIDTH'($urandom);
    wait_done(edges, bnz);
    check({name, "_timeout"}, 32'(edges != 0), 32'd1);
    check({name, "_prod"}, 32'(product), 32'(exp_prod));
    check({name, "_cycle"}, 32'(edges + 1), 32'(exp_cyc));
    @(posedge clk); #1;
    check({name, "_one_pulse"}, 32'(done), 32'd0);
    check({name, "_ready_after"}, 32'(ready), 32'd1);
  endtask

  initial begin
    bit bnz;
    int edges;
    int pulses;
    logic [WIDTH-1:0] ra, rb;

    vecs[0] = '{a: 8'd13,  b: 8'd11,  prod: 16'h008F, cyc: 23};
    vecs[1] = '{a: 8'hFF,  b: 8'hFF,  prod: 16'hFE01, cyc: 33};
    vecs[2] = '{a: 8'hA5,  b: 8'h00,  prod: 16'h0000, cyc: 17};
    vecs[3] = '{a: 8'd7,   b: 8'd9,   prod: 16'd63,   cyc: 21};

    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].cyc, bnz);
      if (vecs[i].b == '0) check("zero_b_alu_b_idle", 32'(bnz), 32'd0);
    end

    for (int i = 0; i < 20; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (i == 0) rb = '1;
      run_op($sformatf("rand%0d", i), ra, rb, (2*WIDTH)'(ra) * (2*WIDTH)'(rb), ref_cycle(rb), bnz);
    end

    // Start held high with operands changing mid-op, then a back-to-back op.
    a_in = 8'd13; b_in = 8'd11; start = 1'b1;
    @(posedge clk); #1;
    a_in = 8'h55; b_in = 8'hF0;
    check("b2b_busy_ready", 32'(ready), 32'd0);
    wait_done(edges, bnz);
    check("b2b_first_timeout", 32'(edges != 0), 32'd1);
    check("b2b_first_prod", 32'(product), 32'h008F);
    check("b2b_first_cycle", 32'(edges + 1), 32'd23);
    @(posedge clk); #1;
    check("b2b_idle_ready", 32'(ready), 32'd1);
    check("b2b_one_pulse", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("b2b_accepted", 32'(ready), 32'd0);
    start = 1'b0;
    check("b2b_prod_held", 32'(product), 32'h008F);
    wait_done(edges, bnz);
    check("b2b_second_timeout", 32'(edges != 0), 32'd1);
    check("b2b_second_prod", 32'(product), 32'(16'h0055 * 16'h00F0));
    check("b2b_second_cycle", 32'(edges + 1), 32'(ref_cycle(8'hF0)));
    @(posedge clk); #1;

    // Reset while the first add is in progress.
    a_in = 8'hFF; b_in = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_add", 32'(alu_s), 32'h9);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_product", 32'(product), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    run_op("after_rst", 8'd7, 8'd9, 16'd63, ref_cycle(8'd9), bnz);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
